multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, maximum cycles a memory state waits for mem_ready before abort (1..255).
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: opcode  input  6  instruction opcode from the instruction register.
REQ-005 Port: zero  input  1  ALU zero flag.
REQ-006 Port: mem_ready  input  1  memory handshake, completes the current access.
REQ-007 Port: sel_operA  output  2  operand-A select: 00 register A, 01 constant 4, 10 immediate_ext, 11 immediate_desp.
REQ-008 Port: sel_operB  output  2  operand-B select: 00 register B, 01 PC, 10 immediate_ext, 11 reserved (never driven).
REQ-009 Port: alu_op  output  2  00 add, 01 subtract, 10 decode funct.
REQ-010 Port: sel_pc  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 Ports (all output, 1 bit): pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write, sel_regdst, sel_memtoreg, illegal_op, bus_error.
REQ-012 Port: state_out  output  4  current state encoding, for debug.

Function
REQ-013 States and encodings SHALL be: S_RESET 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, WB_R 8, EXEC_I 9, WB_I 10, BRANCH 11, JUMP 12; unused encodings go to FETCH.
REQ-014 Outputs SHALL be decoded from the current state only, except FETCH strobes qualified by mem_ready; any output not listed for a state is 0.
REQ-015 S_RESET: all outputs 0; next FETCH unconditionally.
REQ-016 FETCH: mem_read=1, sel_operA=01, sel_operB=01, alu_op=00, sel_pc=00, ir_write=pc_write=mem_ready; advance to DECODE on mem_ready, else stay.
REQ-017 DECODE: sel_operA=11, sel_operB=01, alu_op=00; next by opcode: 000000 EXEC_R, 100011/101011 MEM_ADDR, 001000 EXEC_I, 000100 BRANCH, 000010 JUMP; any other opcode pulses illegal_op for this cycle and returns to FETCH.
REQ-018 MEM_ADDR: sel_operA=00, sel_operB=10, alu_op=00; next MEM_RD for 100011, MEM_WR for 101011.
REQ-019 MEM_RD: mem_read=1, iord=1; to MEM_WB on mem_ready. MEM_WB: reg_write=1, sel_memtoreg=1; to FETCH.
REQ-020 MEM_WR: mem_write=1, iord=1; to FETCH on mem_ready.
REQ-021 EXEC_R: sel_operA=00, sel_operB=00, alu_op=10; to WB_R. WB_R: reg_write=1, sel_regdst=1; to FETCH.
REQ-022 EXEC_I: sel_operA=00, sel_operB=10, alu_op=00; to WB_I. WB_I: reg_write=1; to FETCH.
REQ-023 BRANCH: sel_operA=00, sel_operB=00, alu_op=01, pc_write_cond=1, sel_pc=01; to FETCH regardless of zero.
REQ-024 JUMP: pc_write=1, sel_pc=10; to FETCH.
REQ-025 An 8-bit wait counter SHALL clear on entering FETCH, MEM_RD or MEM_WR and increment each cycle mem_ready is 0 there.
REQ-026 When the counter equals TIMEOUT_CYCLES with mem_ready 0, bus_error SHALL pulse one cycle and the FSM SHALL go to FETCH (MEM_RD/MEM_WR: instruction aborted, no reg_write; FETCH: retried, PC unchanged).
REQ-027 mem_ready in the same cycle as the timeout match SHALL win: normal advance, no bus_error.
REQ-028 Latency without wait states: R/ADDI 4 cycles, LW 5, SW 4, BEQ 3, J 3.

Reset
REQ-029 reset SHALL force state S_RESET and counter 0 immediately, independent of clk; all outputs 0 while asserted, including mid-access (no partial write completes).
REQ-030 First FETCH SHALL occur on the second rising edge after reset deassertion.

Structure
REQ-031 State encodings, opcode constants, sel_operA/sel_operB/alu_op/sel_pc codes SHALL live in a shared definitions header used by the datapath muxes too.
REQ-032 Output decode SHALL be one combinational sub-module, control_decode (state, mem_ready in; control word out); next-state logic and wait counter stay in multicycle_control.

Verification
REQ-033 Reset then opcode 000000, mem_ready always 1 -> states 0,1,2,7,8,1; reg_write=1 and sel_regdst=1 only in WB_R.
REQ-034 LW (100011), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_read=iord=1 throughout, then MEM_WB with sel_memtoreg=1.
REQ-035 BEQ, zero=1 -> BRANCH asserts pc_write_cond=1, sel_pc=01, alu_op=01; returns to FETCH next cycle.
REQ-036 Opcode 111111 -> illegal_op high exactly one cycle in DECODE, next state FETCH, no reg_write/mem_write.
REQ-037 TIMEOUT_CYCLES=4, SW with mem_ready never high -> bus_error pulses once, FSM in FETCH, mem_write deasserted.
REQ-038 reset asserted mid-MEM_WR -> mem_write drops asynchronously, state_out=0, recovery to FETCH after deassertion.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller and the datapath muxes it steers:
// state encodings, opcodes, mux select codes and the control word layout.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    WB_R     = 4'd8,
    EXEC_I   = 4'd9,
    WB_I     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] OPA_REG      = 2'b00;
  localparam logic [1:0] OPA_FOUR     = 2'b01;
  localparam logic [1:0] OPA_IMM_EXT  = 2'b10;
  localparam logic [1:0] OPA_IMM_DESP = 2'b11;

  // Code 11 on operand B is reserved and never driven.
  localparam logic [1:0] OPB_REG     = 2'b00;
  localparam logic [1:0] OPB_PC      = 2'b01;
  localparam logic [1:0] OPB_IMM_EXT = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] sel_opera;
    logic [1:0] sel_operb;
    logic [1:0] alu_op;
    logic [1:0] sel_pc;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       sel_regdst;
    logic       sel_memtoreg;
  } ctrl_t;

  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Moore-style control word decode from the current state; only the FETCH
// instruction-register and PC strobes are qualified by mem_ready.
module control_decode
  import multicycle_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.sel_opera = OPA_FOUR;
        ctrl.sel_operb = OPB_PC;
        ctrl.alu_op    = ALU_ADD;
        ctrl.sel_pc    = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.sel_opera = OPA_IMM_DESP;
        ctrl.sel_operb = OPB_PC;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_ADDR, EXEC_I: begin
        ctrl.sel_opera = OPA_REG;
        ctrl.sel_operb = OPB_IMM_EXT;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write    = 1'b1;
        ctrl.sel_memtoreg = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      EXEC_R: begin
        ctrl.sel_opera = OPA_REG;
        ctrl.sel_operb = OPB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.sel_regdst = 1'b1;
      end
      WB_I: ctrl.reg_write = 1'b1;
      BRANCH: begin
        ctrl.sel_opera     = OPA_REG;
        ctrl.sel_operb     = OPB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.sel_pc        = PC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.sel_pc   = PC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with a memory wait-state counter that aborts
// (memory states) or retries (fetch) an access after TIMEOUT_CYCLES idle cycles.
//
// state    | meaning
// S_RESET  | idle after reset, all strobes low
// FETCH    | read instruction, PC += 4 on mem_ready
// DECODE   | opcode dispatch, branch target precompute
// MEM_ADDR | load/store address calc
// MEM_RD   | data read, waits on mem_ready
// MEM_WB   | load writeback
// MEM_WR   | data write, waits on mem_ready
// EXEC_R   | R-type ALU op
// WB_R     | R-type writeback to rd
// EXEC_I   | ADDI ALU op
// WB_I     | ADDI writeback to rt
// BRANCH   | BEQ compare, conditional PC write
// JUMP     | PC <= jump target
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] sel_operA,
  output logic [1:0] sel_operB,
  output logic [1:0] alu_op,
  output logic [1:0] sel_pc,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       sel_regdst,
  output logic       sel_memtoreg,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state_out
);

  localparam logic [7:0] TIMEOUT_MATCH = 8'(TIMEOUT_CYCLES);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       reset_hold;
  logic       timeout;
  logic       illegal;
  ctrl_t      ctrl;
  logic       zero_unused;

  // The branch decision is taken by the datapath through pc_write_cond.
  assign zero_unused = zero;

  assign timeout = is_wait_state(state) && !mem_ready && (wait_cnt == TIMEOUT_MATCH);

  always_comb begin
    state_next = state;
    illegal    = 1'b0;
    case (state)
      S_RESET: state_next = FETCH;
      FETCH:   if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = EXEC_R;
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_ADDI:      state_next = EXEC_I;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          default: begin
            illegal    = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEM_ADDR: state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_next = MEM_WB;
      MEM_WR:   if (mem_ready) state_next = FETCH;
      EXEC_R:   state_next = WB_R;
      EXEC_I:   state_next = WB_I;
      MEM_WB, WB_R, WB_I, BRANCH, JUMP: state_next = FETCH;
      default:  state_next = FETCH;
    endcase
    if (timeout) state_next = FETCH;
  end

  // reset_hold keeps S_RESET for one extra edge after release, so the first
  // FETCH lands on the second rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_RESET;
      wait_cnt   <= 8'd0;
      reset_hold <= 1'b1;
    end else begin
      reset_hold <= 1'b0;
      state      <= reset_hold ? S_RESET : state_next;
      if (reset_hold || (state_next != state) || timeout)
        wait_cnt <= 8'd0;
      else if (is_wait_state(state) && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  control_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign sel_operA     = ctrl.sel_opera;
  assign sel_operB     = ctrl.sel_operb;
  assign alu_op        = ctrl.alu_op;
  assign sel_pc        = ctrl.sel_pc;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ir_write      = ctrl.ir_write;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign iord          = ctrl.iord;
  assign reg_write     = ctrl.reg_write;
  assign sel_regdst    = ctrl.sel_regdst;
  assign sel_memtoreg  = ctrl.sel_memtoreg;
  assign illegal_op    = illegal;
  assign bus_error     = timeout;
  assign state_out     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with TIMEOUT_CYCLES=4: instruction flows,
// wait states, illegal opcode, bus timeouts, and asynchronous reset mid-write.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] sel_operA, sel_operB, alu_op, sel_pc;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord;
  logic       reg_write, sel_regdst, sel_memtoreg, illegal_op, bus_error;
  logic [3:0] state_out;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .sel_operA     (sel_operA),
    .sel_operB     (sel_operB),
    .alu_op        (alu_op),
    .sel_pc        (sel_pc),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .iord          (iord),
    .reg_write     (reg_write),
    .sel_regdst    (sel_regdst),
    .sel_memtoreg  (sel_memtoreg),
    .illegal_op    (illegal_op),
    .bus_error     (bus_error),
    .state_out     (state_out)
  );

  always #5 clk = ~clk;

  logic [20:0] all_out;
  assign all_out = {sel_operA, sel_operB, alu_op, sel_pc, pc_write, pc_write_cond,
                    ir_write, mem_read, mem_write, iord, reg_write, sel_regdst,
                    sel_memtoreg, illegal_op, bus_error};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_state(input string tag, input logic [3:0] exp);
    @(negedge clk);
    check(tag, 32'(state_out), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_outputs", 32'(all_out), 32'd0);

    // R-type, no wait states: 0,0,1,2,7,8,1
    reset = 1'b0;
    step_state("r_hold", 4'd0);
    step_state("r_fetch", 4'd1);
    check("r_fetch_ir", 32'(ir_write), 32'd1);
    check("r_fetch_pc", 32'(pc_write), 32'd1);
    check("r_fetch_opab", 32'({sel_operA, sel_operB}), 32'h5);
    step_state("r_decode", 4'd2);
    check("r_decode_opa", 32'(sel_operA), 32'd3);
    step_state("r_exec", 4'd7);
    check("r_exec_alu", 32'(alu_op), 32'd2);
    check("r_exec_nowr", 32'(reg_write), 32'd0);
    step_state("r_wb", 4'd8);
    check("r_wb_wr", 32'({reg_write, sel_regdst}), 32'h3);
    step_state("r_back", 4'd1);

    // LW with three wait cycles in MEM_RD
    opcode = 6'b100011;
    step_state("lw_decode", 4'd2);
    step_state("lw_addr", 4'd3);
    check("lw_addr_opb", 32'(sel_operB), 32'd2);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_state("lw_rd", 4'd4);
      check("lw_rd_strobes", 32'({mem_read, iord}), 32'h3);
      if (i == 3) mem_ready = 1'b1;
    end
    step_state("lw_wb", 4'd5);
    check("lw_wb_strobes", 32'({reg_write, sel_memtoreg}), 32'h3);
    step_state("lw_back", 4'd1);

    // BEQ with zero=1
    opcode = 6'b000100; zero = 1'b1;
    step_state("beq_decode", 4'd2);
    step_state("beq_branch", 4'd11);
    check("beq_ctl", 32'({pc_write_cond, sel_pc, alu_op}), 32'b1_01_01);
    step_state("beq_back", 4'd1);
    zero = 1'b0;

    // Illegal opcode
    opcode = 6'b111111;
    step_state("ill_decode", 4'd2);
    check("ill_flag", 32'({illegal_op, reg_write, mem_write}), 32'b100);
    step_state("ill_back", 4'd1);
    check("ill_clear", 32'(illegal_op), 32'd0);

    // Jump
    opcode = 6'b000010;
    step_state("j_decode", 4'd2);
    step_state("j_jump", 4'd12);
    check("j_ctl", 32'({pc_write, sel_pc}), 32'b1_10);
    step_state("j_back", 4'd1);

    // ADDI
    opcode = 6'b001000;
    step_state("addi_decode", 4'd2);
    step_state("addi_exec", 4'd9);
    check("addi_exec_ctl", 32'({sel_operA, sel_operB, alu_op}), 32'b00_10_00);
    step_state("addi_wb", 4'd10);
    check("addi_wb_ctl", 32'({reg_write, sel_regdst}), 32'b10);
    step_state("addi_back", 4'd1);

    // SW with mem_ready stuck low: abort after count reaches 4
    opcode = 6'b101011;
    step_state("sw_decode", 4'd2);
    step_state("sw_addr", 4'd3);
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_state("sw_wr", 4'd6);
      check("sw_wr_strobe", 32'(mem_write), 32'd1);
      check("sw_bus_error", 32'(bus_error), (i == 4) ? 32'd1 : 32'd0);
    end
    step_state("sw_abort", 4'd1);
    check("sw_abort_nowr", 32'({mem_write, bus_error}), 32'd0);

    // Fetch retry after timeout, then stays in FETCH with no strobes
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step_state("fetch_wait", 4'd1);
      check("fetch_ir_idle", 32'(ir_write), 32'd0);
      check("fetch_bus_error", 32'(bus_error), (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step_state("fetch_retry", 4'd1);
      check("fetch_retry_be", 32'(bus_error), 32'd0);
    end
    // mem_ready arrives in the very cycle the count matches: ready wins
    @(posedge clk);
    #1 mem_ready = 1'b1;
    @(negedge clk);
    check("race_state", 32'(state_out), 32'd1);
    check("race_no_be", 32'(bus_error), 32'd0);
    check("race_ir", 32'(ir_write), 32'd1);
    step_state("race_decode", 4'd2);

    // Reset asserted in the middle of MEM_WR
    step_state("mid_addr", 4'd3);
    mem_ready = 1'b0;
    step_state("mid_wr", 4'd6);
    check("mid_wr_strobe", 32'(mem_write), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(state_out), 32'd0);
    check("mid_rst_outputs", 32'(all_out), 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1;
    step_state("rec_hold", 4'd0);
    step_state("rec_fetch", 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
